// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath width, the bubble instruction, opcode map and
// the fetch FSM encoding. Imported by the fetch stage, its PC generator and control.
package cpu_pkg;

    localparam int XLEN = 32;

    // addi x0,x0,0: presented whenever the fetch stage holds no live instruction
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_JAL    = 7'h6F;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_IMM    = 7'h13;
    localparam logic [6:0] OP_REG    = 7'h33;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        DRAIN = 2'd3
    } fetch_state_e;

    function automatic logic [31:0] sat_inc(input logic [31:0] value);
        return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
    endfunction

endpackage

// File: rtl/pc_gen.sv
// Program counter register: holds, steps by one word, or loads a word-aligned
// redirect target (redirect wins over increment).
module pc_gen
    import cpu_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            inc_en,
    input  logic            redirect_en,
    input  logic [XLEN-1:0] redirect_target,
    output logic [XLEN-1:0] pc
);

    localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};
    localparam logic [XLEN-1:0] WORD_BYTES = XLEN'(4);

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_d;

    always_comb begin
        pc_d = pc_q;
        if (redirect_en) begin
            pc_d = redirect_target & ALIGN_MASK;
        end else if (inc_en) begin
            pc_d = pc_q + WORD_BYTES;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc = pc_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, fetches over req/ack, registers the instruction
// for control. Define FETCH_PERF_CNT_EN to add fetch/stall/flush counters.
module fetch_stage
    import cpu_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clock,
    input  logic            reset,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            stall,
    input  logic            brnch_taken,
    input  logic [XLEN-1:0] brnch_target,
    output logic [XLEN-1:0] instr,
    output logic [6:0]      opcode,
    output logic [XLEN-1:0] pc_out,
    output logic            instr_valid
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]     fetch_count,
    output logic [31:0]     stall_count,
    output logic [31:0]     flush_count
`endif
);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] instr_q, instr_d;
    logic [XLEN-1:0] pc_out_q, pc_out_d;
    logic            valid_q, valid_d;
    logic [XLEN-1:0] drain_addr_q, drain_addr_d;
    logic [XLEN-1:0] pc;
    logic            pc_inc;
    logic            pc_redirect;

    pc_gen #(
        .RESET_PC (RESET_PC)
    ) u_pc_gen (
        .clock           (clock),
        .reset           (reset),
        .inc_en          (pc_inc),
        .redirect_en     (pc_redirect),
        .redirect_target (brnch_target),
        .pc              (pc)
    );

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        state_d      = state_q;
        instr_d      = instr_q;
        pc_out_d     = pc_out_q;
        valid_d      = valid_q;
        drain_addr_d = drain_addr_q;
        pc_inc       = 1'b0;
        pc_redirect  = 1'b0;

        if (brnch_taken) begin
            pc_redirect = 1'b1;
            valid_d     = 1'b0;
            instr_d     = NOP_INSTR;
            if (state_q == DRAIN) begin
                state_d = DRAIN;
            end else if (state_q == FETCH && !imem_ack) begin
                // The bus still owes an answer at the old address; remember it.
                state_d      = DRAIN;
                drain_addr_d = pc;
            end else begin
                state_d = FETCH;
            end
        end else begin
            if (valid_q && !stall) begin
                valid_d = 1'b0;
                instr_d = NOP_INSTR;
            end
            case (state_q)
                IDLE: state_d = FETCH;
                FETCH: begin
                    if (imem_ack) begin
                        instr_d  = imem_rdata;
                        pc_out_d = pc;
                        valid_d  = 1'b1;
                        pc_inc   = 1'b1;
                        state_d  = stall ? HOLD : FETCH;
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        state_d = FETCH;
                    end
                end
                DRAIN: begin
                    if (imem_ack) begin
                        state_d = FETCH;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            instr_q      <= NOP_INSTR;
            pc_out_q     <= RESET_PC;
            valid_q      <= 1'b0;
            drain_addr_q <= RESET_PC;
        end else begin
            state_q      <= state_d;
            instr_q      <= instr_d;
            pc_out_q     <= pc_out_d;
            valid_q      <= valid_d;
            drain_addr_q <= drain_addr_d;
        end
    end

    assign imem_req    = (state_q == FETCH) || (state_q == DRAIN);
    assign imem_addr   = (state_q == DRAIN) ? drain_addr_q : pc;
    assign instr       = instr_q;
    assign opcode      = instr_q[6:0];
    assign pc_out      = pc_out_q;
    assign instr_valid = valid_q;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_count_q, fetch_count_d;
    logic [31:0] stall_count_q, stall_count_d;
    logic [31:0] flush_count_q, flush_count_d;
    logic        fetch_accept;

    assign fetch_accept = (state_q == FETCH) && imem_ack && !brnch_taken;

    always_comb begin
        fetch_count_d = fetch_accept ? sat_inc(fetch_count_q) : fetch_count_q;
        stall_count_d = (valid_q && stall) ? sat_inc(stall_count_q) : stall_count_q;
        flush_count_d = brnch_taken ? sat_inc(flush_count_q) : flush_count_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            fetch_count_q <= '0;
            stall_count_q <= '0;
            flush_count_q <= '0;
        end else begin
            fetch_count_q <= fetch_count_d;
            stall_count_q <= stall_count_d;
            flush_count_q <= flush_count_d;
        end
    end

    assign fetch_count = fetch_count_q;
    assign stall_count = stall_count_q;
    assign flush_count = flush_count_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed req/ack/stall/branch vectors, a flag-based model of
// the fetch rules compared every cycle, and hand-computed literal spot checks.
module tb_fetch_stage;
    import cpu_pkg::*;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        stall = 1'b0;
    logic        brnch_taken = 1'b0;
    logic [31:0] brnch_target = '0;
    logic [31:0] instr;
    logic [6:0]  opcode;
    logic [31:0] pc_out;
    logic        instr_valid;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_count, stall_count, flush_count;
`endif

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    fetch_stage #(.RESET_PC(RESET_PC)) dut (
        .clock        (clock),
        .reset        (reset),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .stall        (stall),
        .brnch_taken  (brnch_taken),
        .brnch_target (brnch_target),
        .instr        (instr),
        .opcode       (opcode),
        .pc_out       (pc_out),
        .instr_valid  (instr_valid)
`ifdef FETCH_PERF_CNT_EN
        ,
        .fetch_count  (fetch_count),
        .stall_count  (stall_count),
        .flush_count  (flush_count)
`endif
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Memory image: upper bits echo the address, opcode cycles through the opcode map.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [6:0] ops [8];
        ops = '{OP_LUI, OP_JAL, OP_BRANCH, OP_LOAD, OP_STORE, OP_IMM, OP_REG, OP_IMM};
        return {a[26:2], ops[a[4:2]]};
    endfunction

    // ack_mode: 0 = no ack, 1 = ack, 2 = ack whenever a request is up (zero-wait memory)
    task automatic step(input logic rst, input int ack_mode, input logic stl,
                        input logic br, input logic [31:0] tgt);
        @(negedge clock);
        #1;
        reset        = rst;
        stall        = stl;
        brnch_taken  = br;
        brnch_target = tgt;
        imem_ack     = (ack_mode == 2) ? imem_req : (ack_mode == 1);
        imem_rdata   = mem_word(imem_addr);
    endtask

    // Model: flags describing what the stage is doing, updated from the rules per edge.
    logic [31:0] m_pc, m_addr, m_instr, m_pc_out;
    logic        m_pending, m_drop, m_started, m_held, m_valid;
    logic [31:0] m_fetch, m_stall, m_flush;

    always @(posedge clock) begin
        if (reset) begin
            m_pc = RESET_PC;  m_addr = RESET_PC;  m_pc_out = RESET_PC;
            m_instr = NOP_INSTR;
            m_pending = 0; m_drop = 0; m_started = 0; m_held = 0; m_valid = 0;
            m_fetch = 0; m_stall = 0; m_flush = 0;
        end else begin
            if (m_valid && stall && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 1;
            if (brnch_taken) begin
                if (m_flush != 32'hFFFF_FFFF) m_flush = m_flush + 1;
                m_pc      = {brnch_target[31:2], 2'b00};
                m_valid   = 0;
                m_instr   = NOP_INSTR;
                m_started = 1;
                m_held    = 0;
                if (m_pending && (m_drop || !imem_ack)) begin
                    m_drop = 1;
                end else begin
                    m_pending = 1; m_drop = 0; m_addr = m_pc;
                end
            end else begin
                if (m_valid && !stall) begin
                    m_valid = 0; m_instr = NOP_INSTR;
                end
                if (!m_started) begin
                    m_started = 1; m_pending = 1; m_addr = m_pc;
                end else if (m_held) begin
                    if (!stall) begin
                        m_held = 0; m_pending = 1; m_addr = m_pc;
                    end
                end else if (m_pending && imem_ack) begin
                    if (m_drop) begin
                        m_drop = 0; m_addr = m_pc;
                    end else begin
                        m_instr  = imem_rdata;
                        m_pc_out = m_addr;
                        m_valid  = 1;
                        m_pc     = m_pc + 32'd4;
                        if (m_fetch != 32'hFFFF_FFFF) m_fetch = m_fetch + 1;
                        if (stall) begin
                            m_pending = 0; m_held = 1;
                        end else begin
                            m_addr = m_pc;
                        end
                    end
                end
            end
        end
    end

    always @(negedge clock) begin
        if (chk_en) begin
            check("imem_req", {31'b0, imem_req}, {31'b0, m_pending});
            if (m_pending) check("imem_addr", imem_addr, m_addr);
            check("instr", instr, m_instr);
            check("opcode", {25'b0, opcode}, {25'b0, m_instr[6:0]});
            check("pc_out", pc_out, m_pc_out);
            check("instr_valid", {31'b0, instr_valid}, {31'b0, m_valid});
`ifdef FETCH_PERF_CNT_EN
            check("fetch_count", fetch_count, m_fetch);
            check("stall_count", stall_count, m_stall);
            check("flush_count", flush_count, m_flush);
`endif
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish, got running expected done");
        $fatal(1);
    end

    initial begin
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        check("rst_req", {31'b0, imem_req}, 32'd0);
        check("rst_instr", instr, 32'h0000_0013);
        check("rst_opcode", {25'b0, opcode}, 32'h13);
        check("rst_pc_out", pc_out, 32'h0);
        check("rst_valid", {31'b0, instr_valid}, 32'd0);
        chk_en = 1'b1;

        // zero-wait streaming from reset
        step(0, 2, 0, 0, 0);
        step(0, 2, 0, 0, 0);
        check("s4_addr", imem_addr, 32'h0);
        check("s4_req", {31'b0, imem_req}, 32'd1);
        step(0, 2, 0, 0, 0);
        check("s5_addr", imem_addr, 32'h4);
        check("s5_instr", instr, 32'h0000_0037);
        check("s5_pc_out", pc_out, 32'h0);
        step(0, 0, 0, 0, 0);
        check("s6_addr", imem_addr, 32'h8);
        check("s6_instr", instr, 32'h0000_00EF);

        // stall: instruction at 8 lands while stalled, holds for 3 cycles
        step(0, 1, 1, 0, 0);
        check("s7_addr_held", imem_addr, 32'h8);
        check("s7_opcode_nop", {25'b0, opcode}, 32'h13);
        step(0, 2, 1, 0, 0);
        check("hold_req", {31'b0, imem_req}, 32'd0);
        check("hold_pc_out", pc_out, 32'h8);
        check("hold_instr", instr, 32'h0000_0163);
        step(0, 2, 1, 0, 0);
        check("hold_req2", {31'b0, imem_req}, 32'd0);
        step(0, 2, 0, 0, 0);
        check("hold_req3", {31'b0, imem_req}, 32'd0);
        check("hold_pc_out3", pc_out, 32'h8);
        step(0, 2, 0, 0, 0);
        check("resume_addr", imem_addr, 32'hC);
        check("resume_req", {31'b0, imem_req}, 32'd1);

        // branch coincident with ack of 0x10
        step(0, 1, 0, 1, 32'h20);
        check("s12_addr", imem_addr, 32'h10);
        check("s12_instr", instr, 32'h0000_0183);
        // branch to 0x103 while 0x20 is pending, ack two cycles later
        step(0, 0, 0, 1, 32'h103);
        check("br_ack_next_addr", imem_addr, 32'h20);
        check("br_ack_valid", {31'b0, instr_valid}, 32'd0);
        step(0, 0, 0, 0, 0);
        check("drain_addr", imem_addr, 32'h20);
        check("drain_opcode", {25'b0, opcode}, 32'h13);
        step(0, 1, 0, 0, 0);
        check("drain_addr2", imem_addr, 32'h20);
        check("drain_valid", {31'b0, instr_valid}, 32'd0);
        step(0, 2, 0, 0, 0);
        check("after_drain_addr", imem_addr, 32'h100);
        check("after_drain_valid", {31'b0, instr_valid}, 32'd0);

        // reset with request pending, then a stray ack
        step(1, 0, 0, 0, 0);
        check("s17_instr", instr, 32'h0000_2037);
        check("s17_pc_out", pc_out, 32'h100);
        step(0, 1, 0, 0, 0);
        check("stray_req", {31'b0, imem_req}, 32'd0);
        check("stray_pc_out", pc_out, 32'h0);
        check("stray_instr", instr, 32'h0000_0013);

        // wrap: redirect to 0xFFFF_FFFF (aligned to ..FC) from a pending fetch
        step(0, 0, 0, 1, 32'hFFFF_FFFF);
        check("restart_addr", imem_addr, 32'h0);
        step(0, 1, 0, 0, 0);
        check("wrap_drain_addr", imem_addr, 32'h0);
        step(0, 2, 0, 0, 0);
        check("wrap_addr", imem_addr, 32'hFFFF_FFFC);
        step(0, 2, 0, 0, 0);
        check("wrapped_addr", imem_addr, 32'h0);
        check("wrap_pc_out", pc_out, 32'hFFFF_FFFC);
        check("wrap_instr", instr, 32'hFFFF_FF93);
`ifdef FETCH_PERF_CNT_EN
        check("perf_fetch1", fetch_count, 32'd1);
        check("perf_flush1", flush_count, 32'd1);
        check("perf_stall0", stall_count, 32'd0);
`endif
        step(0, 2, 0, 0, 0);
        check("post_wrap_addr", imem_addr, 32'h4);
`ifdef FETCH_PERF_CNT_EN
        check("perf_fetch2", fetch_count, 32'd2);
`endif

        // mixed traffic left to the model
        for (int i = 0; i < 24; i++) begin
            step(0, (i % 4 == 1) ? 0 : 2, (i % 7) >= 5, i == 10, 32'h0000_0200 + i);
        end
        for (int i = 0; i < 4; i++) step(0, 2, 0, 0, 0);

        @(negedge clock);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction fetch stage directly upstream of the control decoder.
- Owns the PC and issues word requests to instruction memory over a req/ack handshake.
- Registers the returned instruction and presents its opcode field to control.
- Honours downstream stall and redirects on a taken branch, flushing anything in flight.

Parameters:
- XLEN, 32, address/instruction width.
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- NOP_INSTR, 32'h0000_0013, instruction presented while not valid (addi x0,x0,0).

Ports:
- clock  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high
- imem_req  out  1  fetch request
- imem_addr  out  XLEN  word address, bits[1:0]=0
- imem_ack  in  1  memory returns data this cycle
- imem_rdata  in  XLEN  instruction word, valid with imem_ack
- stall  in  1  downstream cannot accept a new instruction
- brnch_taken  in  1  one-cycle redirect pulse
- brnch_target  in  XLEN  redirect address
- instr  out  XLEN  registered instruction (NOP_INSTR when invalid)
- opcode  out  7  instr[6:0], feeds control
- pc_out  out  XLEN  PC of instr
- instr_valid  out  1  instr holds a live instruction

Behaviour:
- Reset, synchronous and active-high, wins over everything:
  - pc=RESET_PC, state=IDLE, imem_req=0, instr=NOP_INSTR, opcode=7'h13, pc_out=RESET_PC, instr_valid=0.
  - Reset mid-request drops it; a later stray ack is ignored because state is IDLE.
- States:
  - IDLE: next cycle goes to FETCH.
  - FETCH: imem_req=1, imem_addr=pc. imem_addr is held stable until imem_ack.
  - On ack in FETCH:
    - instr<=imem_rdata, pc_out<=pc, instr_valid<=1, pc<=pc+4 (mod 2^XLEN, wraps to 0).
    - stall=0 at the ack edge: stay in FETCH. The next request (pc+4) is issued the following cycle, giving one instruction per cycle with zero-wait memory.
    - stall=1 at the ack edge: go to HOLD.
  - HOLD: imem_req=0; instr, pc_out and instr_valid are frozen. When stall=0, go to FETCH.
  - DRAIN: entered on a branch while a request is outstanding. imem_req stays 1 at the old address until ack; that data is discarded; then FETCH at the new pc.
- Consumption:
  - With instr_valid=1 and stall=0, the instruction is consumed at the edge.
  - If no new ack arrives that edge: instr_valid<=0, instr<=NOP_INSTR.
- Branch:
  - brnch_taken=1 has priority over stall and over ack.
  - Actions: pc<=brnch_target with bits[1:0] forced to 0; instr_valid<=0; instr<=NOP_INSTR.
  - Same-cycle imem_ack data is discarded.
  - From FETCH with no ack that cycle: go to DRAIN. From FETCH-with-ack, HOLD, or IDLE: go to FETCH.
  - Branch during DRAIN: retarget pc, remain in DRAIN.
- opcode is always instr[6:0]. Control therefore sees 7'h13 whenever invalid and raises no reg_wr/mem_wr side effects.
- Stall while instr_valid=0 does not block fetching. A fetched instruction then lands and HOLD follows.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- When defined, adds output ports:
  - fetch_count (32): increments on each accepted (non-discarded) ack.
  - stall_count (32): increments each cycle instr_valid=1 and stall=1.
  - flush_count (32): increments per brnch_taken.
- All counters reset to 0 and saturate at 32'hFFFF_FFFF.
- When undefined, the ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package cpu_pkg holds:
  - XLEN
  - NOP_INSTR
  - opcode constants (OP_LUI, OP_JAL, OP_BRANCH, OP_LOAD, OP_STORE, OP_IMM, OP_REG) shared with control
  - fetch state encoding IDLE/FETCH/HOLD/DRAIN
- One sub-module, pc_gen: the PC register with increment, redirect and alignment masking. The FSM stays in fetch_stage.

Test Plan:
- Reset then zero-wait memory (ack every cycle of req) -> addresses 0,4,8,12 on consecutive cycles; instr_valid=1 continuously from cycle 3; opcode tracks rdata[6:0].
- Stall high for 3 cycles after the instr at pc 8 is accepted -> instr and pc_out=8 frozen, imem_req=0 for 3 cycles; resumes at addr 12 the cycle after stall drops.
- brnch_taken with target 0x103 while a request to 0x20 is pending (ack 2 cycles later) -> DRAIN: addr 0x20 held, its data discarded; next request at 0x100; instr_valid=0 with opcode 7'h13 throughout.
- brnch_taken coincident with ack of 0x10 data -> data dropped, instr_valid=0; next addr = target.
- Reset asserted while req pending, stray ack arrives next cycle -> ack ignored; outputs at reset values; fetch restarts at RESET_PC.
- PC at 0xFFFF_FFFC, ack -> next imem_addr 0x0000_0000; with FETCH_PERF_CNT_EN, fetch_count increments by exactly 1 per accepted ack.
